unpack_sched: RTL and testbench

//  Round-robin scheduler that shares one word-serialising datapath between NREQ requesters.

---
 rtl/unpack_sched_pkg.sv | 9 +
 rtl/unpack_sched_rr_arbiter.sv | 41 ++++
 rtl/unpack_sched.sv | 115 +++++++++++
 tb/tb_unpack_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/unpack_sched_pkg.sv
// Shared helpers for the unpack scheduler: width derivation for index fields.
package unpack_sched_pkg;

   // Width of an index into n items, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
   endfunction

endpackage

// File: rtl/unpack_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: i_req   - request vector
//        i_ptr   - highest-priority index this cycle
//        o_gnt_oh  - one-hot grant (zero when no request)
//        o_gnt_idx - binary index of the grant
//        o_any     - at least one request present
module rr_arbiter
   import unpack_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   localparam int unsigned SRCW = clog2_min1(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [SRCW-1:0] i_ptr,
   output logic [NREQ-1:0] o_gnt_oh,
   output logic [SRCW-1:0] o_gnt_idx,
   output logic            o_any
);

   // Walk ptr, ptr+1, ... with explicit wrap so non-power-of-2 NREQ works.
   always_comb begin
      int unsigned v_sum;
      logic [SRCW-1:0] v_cand;
      o_gnt_oh  = '0;
      o_gnt_idx = '0;
      o_any     = 1'b0;
      v_sum     = 32'd0;
      v_cand    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         v_sum = 32'(i_ptr) + k;
         if (v_sum >= NREQ) v_sum = v_sum - NREQ;
         v_cand = SRCW'(v_sum);
         if (!o_any && i_req[v_cand]) begin
            o_any            = 1'b1;
            o_gnt_idx        = v_cand;
            o_gnt_oh[v_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/unpack_sched.sv
// Round-robin scheduler that grants one requester, captures its packed word
// and emits the elements LSB first as tagged beats on a single stream.
// Ports: clk, rst   - clock, synchronous active-high reset
//        i_req_stb  - per-requester word valid
//        i_req_dat  - packed words, requester i at [i*ARGD*ARGW +: ARGD*ARGW]
//        o_req_rdy  - per-requester accept (one-hot or zero)
//        o_out_stb/o_out_dat/o_out_src/o_out_lst - beat valid, data, source, last
//        i_out_rdy  - downstream accept
module unpack_sched
   import unpack_sched_pkg::*;
#(
   parameter int unsigned ARGW = 8,
   parameter int unsigned ARGD = 2,
   parameter int unsigned NREQ = 4,
   localparam int unsigned SRCW = clog2_min1(NREQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           i_req_stb,
   input  logic [NREQ*ARGD*ARGW-1:0] i_req_dat,
   output logic [NREQ-1:0]           o_req_rdy,
   output logic                      o_out_stb,
   output logic [ARGW-1:0]           o_out_dat,
   output logic [SRCW-1:0]           o_out_src,
   output logic                      o_out_lst,
   input  logic                      i_out_rdy
);

   localparam int unsigned IDXW  = clog2_min1(ARGD);
   localparam int unsigned WORDW = ARGD * ARGW;

   typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [WORDW-1:0]  r_buf,   w_buf_nxt;
   logic [IDXW-1:0]   r_idx,   w_idx_nxt;
   logic [SRCW-1:0]   r_ptr,   w_ptr_nxt;
   logic [SRCW-1:0]   r_src,   w_src_nxt;
   logic              r_lst,   w_lst_nxt;

   logic [NREQ-1:0]   w_gnt_oh;
   logic [SRCW-1:0]   w_gnt_idx;
   logic              w_any;
   logic              w_last;
   logic              w_load_ok;
   logic              w_accept;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req     (i_req_stb),
      .i_ptr     (r_ptr),
      .o_gnt_oh  (w_gnt_oh),
      .o_gnt_idx (w_gnt_idx),
      .o_any     (w_any)
   );

   assign w_last    = (r_idx == IDXW'(ARGD - 1));
   // A new word may load when idle or as the final beat leaves.
   assign w_load_ok = (r_state == S_IDLE) ||
                      ((r_state == S_SEND) && i_out_rdy && w_last);
   assign w_accept  = w_load_ok && w_any;
   assign o_req_rdy = w_load_ok ? w_gnt_oh : '0;

   // Next-state and datapath update.
   always_comb begin
      w_state_nxt = r_state;
      w_buf_nxt   = r_buf;
      w_idx_nxt   = r_idx;
      w_ptr_nxt   = r_ptr;
      w_src_nxt   = r_src;
      case (r_state)
         S_IDLE: ;
         S_SEND: begin
            if (i_out_rdy) begin
               if (!w_last) w_idx_nxt = r_idx + IDXW'(1);
               else         w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // An accept on the final beat overrides the return to idle.
      if (w_accept) begin
         w_state_nxt = S_SEND;
         w_buf_nxt   = i_req_dat[w_gnt_idx*WORDW +: WORDW];
         w_src_nxt   = w_gnt_idx;
         w_idx_nxt   = '0;
         w_ptr_nxt   = (w_gnt_idx == SRCW'(NREQ - 1)) ? '0 : w_gnt_idx + SRCW'(1);
      end
      w_lst_nxt = (w_state_nxt == S_SEND) && (w_idx_nxt == IDXW'(ARGD - 1));
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_buf   <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_src   <= '0;
         r_lst   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_buf   <= w_buf_nxt;
         r_idx   <= w_idx_nxt;
         r_ptr   <= w_ptr_nxt;
         r_src   <= w_src_nxt;
         r_lst   <= w_lst_nxt;
      end
   end

   assign o_out_stb = (r_state == S_SEND);
   assign o_out_dat = r_buf[r_idx*ARGW +: ARGW];
   assign o_out_src = r_src;
   assign o_out_lst = r_lst;

endmodule

// File: tb/tb_unpack_sched.sv
// Directed bench for unpack_sched: main instance (ARGW=8, ARGD=2, NREQ=4)
// and a pure-arbiter instance (ARGW=8, ARGD=1, NREQ=3).
module tb_unpack_sched;

   logic        clk;
   logic        rst;

   logic [3:0]  req_stb;
   logic [63:0] req_dat;
   logic [3:0]  req_rdy;
   logic        out_stb;
   logic [7:0]  out_dat;
   logic [1:0]  out_src;
   logic        out_lst;
   logic        out_rdy;

   logic [2:0]  b_req_stb;
   logic [23:0] b_req_dat;
   logic [2:0]  b_req_rdy;
   logic        b_out_stb;
   logic [7:0]  b_out_dat;
   logic [1:0]  b_out_src;
   logic        b_out_lst;
   logic        b_out_rdy;

   int n_chk;
   int n_pass;

   unpack_sched #(.ARGW(8), .ARGD(2), .NREQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req_stb (req_stb),
      .i_req_dat (req_dat),
      .o_req_rdy (req_rdy),
      .o_out_stb (out_stb),
      .o_out_dat (out_dat),
      .o_out_src (out_src),
      .o_out_lst (out_lst),
      .i_out_rdy (out_rdy)
   );

   unpack_sched #(.ARGW(8), .ARGD(1), .NREQ(3)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .i_req_stb (b_req_stb),
      .i_req_dat (b_req_dat),
      .o_req_rdy (b_req_rdy),
      .o_out_stb (b_out_stb),
      .o_out_dat (b_out_dat),
      .o_out_src (b_out_src),
      .o_out_lst (b_out_lst),
      .i_out_rdy (b_out_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input logic [7:0] d, input logic [1:0] s, input logic l);
      chk({tag, ".stb"}, 32'(out_stb), 32'd1);
      chk({tag, ".dat"}, 32'(out_dat), 32'(d));
      chk({tag, ".src"}, 32'(out_src), 32'(s));
      chk({tag, ".lst"}, 32'(out_lst), 32'(l));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      rst       = 1'b1;
      req_stb   = '0;
      req_dat   = '0;
      out_rdy   = 1'b1;
      b_req_stb = '0;
      b_req_dat = '0;
      b_out_rdy = 1'b1;
      do_reset();

      // Reset state
      chk("rst.stb", 32'(out_stb), 32'd0);
      chk("rst.dat", 32'(out_dat), 32'd0);
      chk("rst.src", 32'(out_src), 32'd0);
      chk("rst.lst", 32'(out_lst), 32'd0);
      chk("rst.rdy", 32'(req_rdy), 32'd0);

      // 1. Single request
      req_dat[31:16] = 16'hBEEF;
      req_stb = 4'b0010;
      #1;
      chk("t1.rdy", 32'(req_rdy), 32'h2);
      tick();
      req_stb = '0;
      beat("t1.b0", 8'hEF, 2'd1, 1'b0);
      tick();
      beat("t1.b1", 8'hBE, 2'd1, 1'b1);
      tick();
      chk("t1.idle", 32'(out_stb), 32'd0);

      // 2. All four requesting, zero-bubble round robin from ptr=0
      do_reset();
      for (int i = 0; i < 4; i++)
         req_dat[i*16 +: 16] = {8'h20 + 8'(i), 8'h10 + 8'(i)};
      req_stb = 4'b1111;
      #1;
      chk("t2.rdy", 32'(req_rdy), 32'h1);
      tick();
      for (int b = 0; b < 16; b++) begin
         logic [1:0] s;
         s = 2'((b / 2) % 4);
         if (b == 15) req_stb = '0;
         beat($sformatf("t2.b%0d", b), (b % 2 == 1) ? 8'h20 + 8'(s) : 8'h10 + 8'(s),
              s, 1'((b % 2)));
         tick();
      end
      chk("t2.idle", 32'(out_stb), 32'd0);

      // 3. Backpressure after the first beat
      req_dat[15:0] = 16'h5A3C;
      req_stb = 4'b0001;
      tick();
      req_stb = 4'b1000;
      out_rdy = 1'b0;
      beat("t3.b0", 8'h3C, 2'd0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         beat($sformatf("t3.hold%0d", c), 8'h3C, 2'd0, 1'b0);
         chk($sformatf("t3.rdy%0d", c), 32'(req_rdy), 32'd0);
      end
      req_stb = '0;
      out_rdy = 1'b1;
      tick();
      beat("t3.b1", 8'h5A, 2'd0, 1'b1);
      tick();
      chk("t3.idle", 32'(out_stb), 32'd0);

      // 4. Fairness: serve src3 (ptr wraps to 0), then src1 before src2
      req_dat = {16'h7766, 16'h4433, 16'h2211, 16'h1100};
      req_stb = 4'b1000;
      #1;
      chk("t4.rdy3", 32'(req_rdy), 32'h8);
      tick();
      req_stb = '0;
      beat("t4.s3b0", 8'h66, 2'd3, 1'b0);
      tick();
      tick();
      chk("t4.idle", 32'(out_stb), 32'd0);
      req_stb = 4'b0110;
      #1;
      chk("t4.rdy1", 32'(req_rdy), 32'h2);
      tick();
      beat("t4.s1b0", 8'h11, 2'd1, 1'b0);
      tick();
      beat("t4.s1b1", 8'h22, 2'd1, 1'b1);
      chk("t4.rdy2", 32'(req_rdy), 32'h4);
      tick();
      req_stb = '0;
      beat("t4.s2b0", 8'h33, 2'd2, 1'b0);
      tick();
      beat("t4.s2b1", 8'h44, 2'd2, 1'b1);
      tick();
      chk("t4.end", 32'(out_stb), 32'd0);

      // 5. Reset mid-word from src2 (ptr is 3 here)
      req_dat = {16'h0000, 16'hD2C2, 16'h0000, 16'hB0A0};
      req_stb = 4'b0100;
      tick();
      req_stb = '0;
      beat("t5.b0", 8'hC2, 2'd2, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5.stb", 32'(out_stb), 32'd0);
      req_stb = 4'b0101;
      #1;
      chk("t5.rdy", 32'(req_rdy), 32'h1);
      tick();
      req_stb = '0;
      beat("t5.s0b0", 8'hA0, 2'd0, 1'b0);
      tick();
      beat("t5.s0b1", 8'hB0, 2'd0, 1'b1);
      tick();
      chk("t5.idle", 32'(out_stb), 32'd0);

      // 6. ARGD=1, NREQ=3: pure registered round-robin arbiter with wrap
      b_req_dat = {8'h33, 8'h22, 8'h11};
      b_req_stb = 3'b111;
      tick();
      for (int b = 0; b < 5; b++) begin
         logic [1:0] s;
         s = 2'(b % 3);
         chk($sformatf("t6.b%0d.stb", b), 32'(b_out_stb), 32'd1);
         chk($sformatf("t6.b%0d.src", b), 32'(b_out_src), 32'(s));
         chk($sformatf("t6.b%0d.dat", b), 32'(b_out_dat), 32'(8'h11 * (8'(s) + 8'd1)));
         chk($sformatf("t6.b%0d.lst", b), 32'(b_out_lst), 32'd1);
         if (b == 4) b_req_stb = '0;
         tick();
      end
      chk("t6.idle", 32'(b_out_stb), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
